// File: rtl/m68k_bus_arbiter.sv
// rtl/m68k_bus_arbiter.sv - 68000 bus ownership arbiter (BR/BG/BGACK handshake, grant timeout)
// Optional 3-wire BGACK ownership mode enabled by defining ARB_BGACK_EN.
module m68k_bus_arbiter #(
  parameter int GRANT_TIMEOUT = 255,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       M68K_CLK,
  input  logic       M68K_RESET_n,
  input  logic       arb_enable,
  input  logic       client_idle,
  input  logic       release_req,
  input  logic       M68K_BG_n,
  input  logic       M68K_AS_n_in,
  input  logic       M68K_DTACK_n_in,
  input  logic       M68K_BGACK_n_in,
  output logic       M68K_BR_n_oe,
  output logic       M68K_BGACK_n_oe,
  output logic       bus_granted,
  output logic       host_absent,
  output logic [2:0] arb_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    SETTLE  = 3'd2,
    OWN     = 3'd3,
    DRAIN   = 3'd4,
    RELEASE = 3'd5
  } state_t;

  localparam int TW = $clog2(GRANT_TIMEOUT + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(GRANT_TIMEOUT);
  localparam logic [SW-1:0] ST_MAX = SW'(SETTLE_CYCLES);

`ifdef ARB_BGACK_EN
  localparam logic BGACK_MODE = 1'b1;
`else
  localparam logic BGACK_MODE = 1'b0;
`endif

  state_t        state;
  logic [TW-1:0] to_cnt;
  logic [TW-1:0] to_next;
  logic [SW-1:0] settle_cnt;
  logic [SW-1:0] settle_next;
  logic          br_q;
  logic          bgack_q;
  logic          granted_q;
  logic          absent_q;
  logic          block_req;
  logic [1:0]    bg_sync;
  logic [1:0]    as_sync;
  logic [1:0]    dtack_sync;
  logic [1:0]    bgack_sync;
  logic          bg_low;
  logic          bus_quiet;

  // Two-flop synchronisers; idle (high) is the safe reset value for active-low bus lines.
  always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
    if (!M68K_RESET_n) begin
      bg_sync    <= 2'b11;
      as_sync    <= 2'b11;
      dtack_sync <= 2'b11;
      bgack_sync <= 2'b11;
    end else begin
      bg_sync    <= {bg_sync[0], M68K_BG_n};
      as_sync    <= {as_sync[0], M68K_AS_n_in};
      dtack_sync <= {dtack_sync[0], M68K_DTACK_n_in};
      bgack_sync <= {bgack_sync[0], M68K_BGACK_n_in};
    end
  end

  assign bg_low      = ~bg_sync[1];
  assign bus_quiet   = as_sync[1] & dtack_sync[1] & bgack_sync[1];
  assign to_next     = (to_cnt == TO_MAX) ? to_cnt : to_cnt + TW'(1);
  assign settle_next = settle_cnt + SW'(1);

  always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
    if (!M68K_RESET_n) begin
      state      <= IDLE;
      to_cnt     <= '0;
      settle_cnt <= '0;
      br_q       <= 1'b0;
      bgack_q    <= 1'b0;
      granted_q  <= 1'b0;
      absent_q   <= 1'b0;
      block_req  <= 1'b0;
    end else begin
      if (!release_req) block_req <= 1'b0;
      case (state)
        IDLE: begin
          // After a release, stay put until the client withdraws release_req.
          if (arb_enable && !(block_req && release_req)) begin
            state  <= REQ;
            br_q   <= 1'b1;
            to_cnt <= '0;
          end
        end
        REQ: begin
          if (!arb_enable) begin
            state  <= IDLE;
            br_q   <= 1'b0;
            to_cnt <= '0;
          end else if (bg_low) begin
            state      <= SETTLE;
            to_cnt     <= '0;
            settle_cnt <= '0;
          end else if (to_next == TO_MAX) begin
            absent_q   <= 1'b1;
            state      <= SETTLE;
            to_cnt     <= '0;
            settle_cnt <= '0;
          end else begin
            to_cnt <= to_next;
          end
        end
        SETTLE: begin
          if (!bus_quiet) begin
            settle_cnt <= '0;
          end else if (settle_next == ST_MAX) begin
            state      <= OWN;
            granted_q  <= 1'b1;
            bgack_q    <= BGACK_MODE;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_next;
          end
        end
        OWN: begin
          // In 3-wire mode BR drops the cycle after BGACK is asserted.
          br_q <= ~BGACK_MODE;
          if (release_req || !arb_enable) state <= DRAIN;
        end
        DRAIN: begin
          br_q <= ~BGACK_MODE;
          if (client_idle) begin
            state     <= RELEASE;
            br_q      <= 1'b0;
            bgack_q   <= 1'b0;
            granted_q <= 1'b0;
            block_req <= release_req;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          br_q      <= 1'b0;
          bgack_q   <= 1'b0;
          granted_q <= 1'b0;
        end
      endcase
    end
  end

  assign M68K_BR_n_oe    = br_q;
  assign M68K_BGACK_n_oe = bgack_q;
  assign bus_granted     = granted_q;
  assign host_absent     = absent_q;
  assign arb_state       = state;

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// tb/tb_m68k_bus_arbiter.sv - self-checking bench for m68k_bus_arbiter
// Table-driven grant/release vectors plus hand sequences for timeout, busy bus and reset.
module tb_m68k_bus_arbiter;

  localparam logic [2:0] S_IDLE = 3'd0, S_REQ = 3'd1, S_SETTLE = 3'd2,
                         S_OWN = 3'd3, S_DRAIN = 3'd4, S_RELEASE = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       arb_enable = 1'b0;
  logic       client_idle = 1'b1;
  logic       release_req = 1'b0;
  logic       bg_n = 1'b1;
  logic       as_n = 1'b1;
  logic       dtack_n = 1'b1;
  logic       bgack_n_in = 1'b1;
  logic       br_oe;
  logic       bgack_oe;
  logic       bus_granted;
  logic       host_absent;
  logic [2:0] arb_state;

  m68k_bus_arbiter dut (
    .M68K_CLK        (clk),
    .M68K_RESET_n    (rst_n),
    .arb_enable      (arb_enable),
    .client_idle     (client_idle),
    .release_req     (release_req),
    .M68K_BG_n       (bg_n),
    .M68K_AS_n_in    (as_n),
    .M68K_DTACK_n_in (dtack_n),
    .M68K_BGACK_n_in (bgack_n_in),
    .M68K_BR_n_oe    (br_oe),
    .M68K_BGACK_n_oe (bgack_oe),
    .bus_granted     (bus_granted),
    .host_absent     (host_absent),
    .arb_state       (arb_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic       br;
    logic       bgk;
    logic       gr;
    logic       ha;
  } exp_t;

  typedef struct {
    logic       en;
    logic       idle;
    logic       rel;
    logic       bg;
    logic [2:0] st;
    logic       gr;
    logic       ha;
  } vec_t;

  exp_t       sb[$];
  vec_t       tbl[24];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [2:0] prev_st = S_IDLE;

  // Expected {BR_n_oe, BGACK_n_oe} given the expected state and the state one cycle earlier.
  function automatic logic [1:0] exp_oe(input logic [2:0] st, input logic [2:0] prev);
    case (st)
      S_REQ, S_SETTLE: return 2'b10;
      S_OWN, S_DRAIN: begin
`ifdef ARB_BGACK_EN
        return (prev == S_OWN || prev == S_DRAIN) ? 2'b01 : 2'b11;
`else
        return 2'b10;
`endif
      end
      default: return 2'b00;
    endcase
  endfunction

  task automatic push_exp(input string tag, input logic [2:0] st, input logic gr, input logic ha);
    exp_t e;
    logic [1:0] oe;
    oe    = exp_oe(st, prev_st);
    e.tag = tag;
    e.st  = st;
    e.br  = oe[1];
    e.bgk = oe[0];
    e.gr  = gr;
    e.ha  = ha;
    sb.push_back(e);
    prev_st = st;
  endtask

  task automatic pop_check();
    exp_t e;
    logic [6:0] act;
    logic [6:0] req;
    e   = sb.pop_front();
    act = {arb_state, br_oe, bgack_oe, bus_granted, host_absent};
    req = {e.st, e.br, e.bgk, e.gr, e.ha};
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got st=%0d br=%b bgk=%b gr=%b ha=%b, want st=%0d br=%b bgk=%b gr=%b ha=%b",
               e.tag, act[6:4], act[3], act[2], act[1], act[0],
               req[6:4], req[3], req[2], req[1], req[0]);
    end
  endtask

  // Inputs are already set by the caller; expectation applies after the next rising edge.
  task automatic cycle(input string tag, input logic [2:0] st, input logic gr, input logic ha);
    push_exp(tag, st, gr, ha);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic check_now(input string tag, input logic [2:0] st, input logic gr, input logic ha);
    push_exp(tag, st, gr, ha);
    pop_check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Host grant after 10 cycles of BR, then release while a transfer is in flight.
    for (int i = 0; i < 10; i++) tbl[i] = '{1'b1, 1'b1, 1'b0, 1'b1, S_REQ, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, S_REQ,    1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, S_REQ,    1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, S_SETTLE, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, S_SETTLE, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, S_OWN,    1'b1, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, S_OWN,    1'b1, 1'b0};
    for (int i = 16; i < 20; i++) tbl[i] = '{1'b1, 1'b0, 1'b1, 1'b0, S_DRAIN, 1'b1, 1'b0};
    tbl[20] = '{1'b1, 1'b1, 1'b1, 1'b1, S_RELEASE, 1'b0, 1'b0};
    tbl[21] = '{1'b1, 1'b1, 1'b1, 1'b1, S_IDLE,    1'b0, 1'b0};
    tbl[22] = '{1'b1, 1'b1, 1'b1, 1'b1, S_IDLE,    1'b0, 1'b0};
    tbl[23] = '{1'b1, 1'b1, 1'b0, 1'b1, S_REQ,     1'b0, 1'b0};

    @(posedge clk);
    #1;
    check_now("reset_state", S_IDLE, 1'b0, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      arb_enable  = tbl[i].en;
      client_idle = tbl[i].idle;
      release_req = tbl[i].rel;
      bg_n        = tbl[i].bg;
      cycle($sformatf("grant_vec%0d", i), tbl[i].st, tbl[i].gr, tbl[i].ha);
    end

    // Busy bus: DTACK held low 5 cycles while BG is granted.
    bg_n = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      dtack_n = (k <= 5) ? 1'b0 : 1'b1;
      cycle($sformatf("busy_k%0d", k), (k < 3) ? S_REQ : ((k < 9) ? S_SETTLE : S_OWN),
            (k >= 9), 1'b0);
    end

    // No host: BG stays high, timeout must fire at REQ cycle 255.
    rst_n = 1'b0;
    bg_n  = 1'b1;
    #1;
    check_now("reset_before_nohost", S_IDLE, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k <= 258; k++) begin
      cycle($sformatf("nohost_e%0d", k),
            (k <= 254) ? S_REQ : ((k <= 256) ? S_SETTLE : S_OWN),
            (k >= 257), (k >= 255));
    end

    // Asynchronous reset while owning the bus.
    rst_n = 1'b0;
    #2;
    check_now("reset_mid_own", S_IDLE, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Grant arrives in sync exactly on the timeout cycle: grant wins.
    for (int k = 0; k <= 258; k++) begin
      if (k == 253) bg_n = 1'b0;
      cycle($sformatf("simul_e%0d", k),
            (k <= 254) ? S_REQ : ((k <= 256) ? S_SETTLE : S_OWN),
            (k >= 257), 1'b0);
    end

    // arb_enable drop while owning: drain, release, then stay idle.
    arb_enable  = 1'b0;
    client_idle = 1'b0;
    cycle("disable_drain", S_DRAIN, 1'b1, 1'b0);
    client_idle = 1'b1;
    cycle("disable_release", S_RELEASE, 1'b0, 1'b0);
    cycle("disable_idle0", S_IDLE, 1'b0, 1'b0);
    cycle("disable_idle1", S_IDLE, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/m68k_bus_arbiter.md
Name: m68k_bus_arbiter

Overview:
- Sequences ownership of the host 68000 bus for the Pistorm bus-transfer state machine.
- Runs the full 68000 BR/BG/BGACK handshake toward the host CPU.
- Releases ownership cleanly between transfers on request or on user reset.
- Detects an absent host CPU with a grant timeout and falls back to self-ownership.

Parameters:
- GRANT_TIMEOUT, 255: M68K_CLK cycles to wait for BG_n while in REQ before declaring the host CPU absent.
- SETTLE_CYCLES, 2: M68K_CLK cycles that AS_n, DTACK_n and BGACK_n must stay high before ownership is taken.

Ports:
- M68K_CLK  input  1: 7 MHz bus clock; all state updates on the rising edge.
- M68K_RESET_n  input  1: asynchronous active-low reset (host reset line).
- arb_enable  input  1: Pistorm active; requests bus ownership while high.
- client_idle  input  1: transfer state machine is in its waiting state (no cycle in flight).
- release_req  input  1: client asks to hand the bus back to the host.
- M68K_BG_n  input  1: bus grant from host CPU.
- M68K_AS_n_in  input  1: sampled bus address strobe.
- M68K_DTACK_n_in  input  1: sampled bus DTACK.
- M68K_BGACK_n_in  input  1: sampled BGACK (other masters).
- M68K_BR_n_oe  output  1: drive BR_n low when 1, else tristate.
- M68K_BGACK_n_oe  output  1: drive BGACK_n low when 1, else tristate.
- bus_granted  output  1: Pistorm owns the bus; gates bus driver enables.
- host_absent  output  1: grant timeout occurred since last reset.
- arb_state  output  3: current state code, for debug.

Behaviour:
- Reset (M68K_RESET_n low, asynchronous): state IDLE. All outputs 0. Timeout and settle counters cleared. host_absent cleared.
- Inputs BG_n, AS_n, DTACK_n and BGACK_n are each double-registered before use, so each input has 2 cycles of latency.
- State encoding: IDLE=0, REQ=1, SETTLE=2, OWN=3, DRAIN=4, RELEASE=5.
- IDLE:
  - if arb_enable: go to REQ.
- REQ:
  - BR_n_oe=1.
  - Timeout counter increments each cycle.
  - Synced BG_n low: go to SETTLE and clear the counter.
  - Counter reaches GRANT_TIMEOUT with BG_n still high: set host_absent=1 and go to SETTLE.
  - arb_enable drops: go to IDLE.
- SETTLE:
  - BR_n_oe=1.
  - Settle counter counts consecutive cycles with AS_n, DTACK_n and BGACK_n all high. Any low sample resets the count to 0.
  - Count reaches SETTLE_CYCLES: go to OWN.
- OWN:
  - bus_granted=1.
  - Output details depend on the ARB_BGACK_EN macro (see Optional Feature).
  - release_req=1 or arb_enable=0: go to DRAIN.
- DRAIN:
  - bus_granted stays 1.
  - client_idle=1: go to RELEASE. This guarantees an in-flight transfer completes.
  - No timeout in this state.
- RELEASE:
  - Outputs as IDLE for exactly 1 cycle, then go to IDLE.
  - Re-request is blocked until release_req=0, so there is no immediate bounce.
- Simultaneous events:
  - In REQ, BG_n low and timeout on the same cycle: grant wins; host_absent stays 0.
  - In OWN, release_req and arb_enable=0 together: a single DRAIN.
- A reset mid-operation aborts any state immediately. bus_granted falls asynchronously. The client must treat the reset as an abort.
- The timeout counter saturates and never wraps. The settle counter is width ceil(log2(SETTLE_CYCLES+1)).

Optional Feature:
- Macro: ARB_BGACK_EN.
- Defined:
  - In OWN and DRAIN: BGACK_n_oe=1 and BR_n_oe=0. BR is negated one cycle after BGACK is asserted, per the 68000 3-wire protocol.
  - RELEASE negates BGACK.
- Undefined:
  - BGACK_n_oe is tied 0.
  - BR_n_oe stays 1 throughout SETTLE, OWN and DRAIN (2-wire mode); ownership is held by keeping BR asserted.
  - RELEASE negates BR.

Test Plan:
- Host grant: arb_enable=1, BG_n falls 10 cycles after BR, bus quiet -> bus_granted=1 exactly 2+2 cycles after BG_n falls; with the macro defined, BR_n_oe falls 1 cycle after BGACK_n_oe rises.
- No host: BG_n held high, GRANT_TIMEOUT=255 -> host_absent=1 at cycle 255 of REQ, bus_granted=1 two settle cycles later.
- Bus busy: BG_n low but DTACK_n low for 5 cycles, then high -> OWN entered only after 2 consecutive quiet cycles following DTACK_n release.
- Release during transfer: release_req=1 while client_idle=0 for 4 cycles -> bus_granted held through DRAIN, drops 1 cycle after client_idle=1, and no re-request until release_req=0.
- Reset mid-OWN: M68K_RESET_n low -> all outputs 0 asynchronously, arb_state=0, host_absent=0; after reset releases with arb_enable=1 -> REQ next cycle.
- Simultaneous: BG_n synced low on the same cycle the timeout expires -> SETTLE with host_absent=0.
